// File: rtl/sb_pkg.sv
// Shared types and helpers for the store buffer: entry layout, load/store
// funct3 encodings and the load required-byte mask.
package sb_pkg;

    localparam int SB_DATA_W = 32;
    // Widest word address an entry can hold; narrower addresses are zero-extended.
    localparam int SB_WA_MAX = 30;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef struct packed {
        logic                 valid;
        logic [SB_WA_MAX-1:0] waddr;
        logic [SB_DATA_W-1:0] data;
        logic [3:0]           be;
    } sb_entry_t;

    // Byte lanes a load needs inside its word; unknown encodings read the full word.
    function automatic logic [3:0] sb_req_mask(input logic [2:0] funct3,
                                               input logic [1:0] addr_lo);
        case (funct3)
            F3_B, F3_BU: return 4'b0001 << addr_lo;
            F3_H, F3_HU: return addr_lo[1] ? 4'b1100 : 4'b0011;
            default:     return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/sb_store_align.sv
// Store alignment: turns a MEM-stage store into lane-positioned data and byte
// enables, and flags stores whose address does not fit their size.
module sb_store_align
    import sb_pkg::*;
(
    input  logic [2:0]           i_funct3,
    input  logic [1:0]           i_addr_lo,
    input  logic [SB_DATA_W-1:0] i_data,
    output logic [SB_DATA_W-1:0] o_lane_data,
    output logic [3:0]           o_be,
    output logic                 o_misalign
);

    // Replicate narrow stores across lanes so the enables alone pick the bytes.
    always_comb begin
        o_lane_data = i_data;
        o_be        = 4'b1111;
        o_misalign  = 1'b0;
        case (i_funct3)
            F3_B: begin
                o_lane_data = {4{i_data[7:0]}};
                o_be        = 4'b0001 << i_addr_lo;
            end
            F3_H: begin
                o_lane_data = {2{i_data[15:0]}};
                o_be        = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_misalign  = i_addr_lo[0];
            end
            default: begin
                o_lane_data = i_data;
                o_be        = 4'b1111;
                o_misalign  = (i_addr_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer between EX/MEM and data memory: FIFO of word-aligned entries,
// drained when the memory port is idle, with load forwarding / stall lookup.
// Optional build macro STORE_BUFFER_COALESCE_EN merges a store into the
// youngest entry when both target the same word.
module store_buffer
    import sb_pkg::*;
#(
    parameter int SB_DEPTH   = 4,
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
)(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      st_valid,
    output logic                      st_ready,
    input  logic [DM_ADDRESS-1:0]     st_addr,
    input  logic [DATA_W-1:0]         st_data,
    input  logic [2:0]                st_funct3,
    output logic                      st_misalign,
    input  logic                      ld_valid,
    input  logic [DM_ADDRESS-1:0]     ld_addr,
    input  logic [2:0]                ld_funct3,
    output logic                      ld_hit,
    output logic [DATA_W-1:0]         ld_fwd_data,
    output logic                      ld_stall,
    input  logic                      drain_ok,
    output logic                      mem_write,
    output logic [DM_ADDRESS-1:0]     mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    output logic [3:0]                mem_be,
    output logic                      empty,
    output logic [$clog2(SB_DEPTH):0] count
);

    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WA_W  = DM_ADDRESS - 2;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SB_DEPTH);

    // Control state (reset) and entry payload (not reset; qualified by r_valid).
    logic [SB_DEPTH-1:0] r_valid;
    logic [PTR_W-1:0]    r_head;
    logic [PTR_W-1:0]    r_tail;
    logic [CNT_W-1:0]    r_count;
    logic                r_misalign;
    logic [WA_W-1:0]     r_waddr [SB_DEPTH];
    logic [DATA_W-1:0]   r_data  [SB_DEPTH];
    logic [3:0]          r_be    [SB_DEPTH];

    logic [DATA_W-1:0]   w_lane_data;
    logic [3:0]          w_be;
    logic                w_mis;
    logic [WA_W-1:0]     w_st_waddr;
    logic [WA_W-1:0]     w_ld_waddr;
    logic [PTR_W-1:0]    w_young;
    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_merge_ok;
    logic                w_merge;
    logic                w_push;
    sb_entry_t           w_ent [SB_DEPTH];
    logic [3:0]          w_req;
    logic                w_any;
    logic [PTR_W-1:0]    w_sel;
    logic [PTR_W-1:0]    w_idx;
    logic                w_cover;

    sb_store_align u_align (
        .i_funct3    (st_funct3),
        .i_addr_lo   (st_addr[1:0]),
        .i_data      (st_data),
        .o_lane_data (w_lane_data),
        .o_be        (w_be),
        .o_misalign  (w_mis)
    );

    assign w_st_waddr = st_addr[DM_ADDRESS-1:2];
    assign w_ld_waddr = ld_addr[DM_ADDRESS-1:2];
    assign w_young    = r_tail - PTR_ONE;
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CNT_MAX);
    // A load in MEM owns the memory port, so it blocks the drain.
    assign w_pop      = !w_empty && drain_ok && !ld_valid;

`ifdef STORE_BUFFER_COALESCE_EN
    // Merge into the youngest entry unless that entry is leaving this cycle.
    assign w_merge_ok = !w_empty && (r_waddr[w_young] == w_st_waddr) &&
                        !((w_young == r_head) && w_pop);
`else
    assign w_merge_ok = 1'b0;
`endif

    // A merge needs no free slot, so it may proceed while full.
    assign w_merge = st_valid && !w_mis && w_merge_ok;
    assign w_push  = st_valid && !w_mis && !w_merge && !w_full;

    // Pointer, occupancy and misalign-pulse tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= st_valid && w_mis;
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PTR_ONE;
            end
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry payload write: allocate at tail, or merge bytes into the youngest entry.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_waddr[r_tail] <= w_st_waddr;
            r_data[r_tail]  <= w_lane_data;
            r_be[r_tail]    <= w_be;
        end else if (w_merge) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_data[w_young][8*b +: 8] <= w_lane_data[8*b +: 8];
                end
            end
            r_be[w_young] <= r_be[w_young] | w_be;
        end
    end

    // Entry view used by the lookup.
    always_comb begin
        for (int i = 0; i < SB_DEPTH; i++) begin
            w_ent[i].valid = r_valid[i];
            w_ent[i].waddr = SB_WA_MAX'(r_waddr[i]);
            w_ent[i].data  = r_data[i];
            w_ent[i].be    = r_be[i];
        end
    end

    // Load lookup: walk oldest to youngest so the last match is the youngest.
    always_comb begin
        w_req   = sb_req_mask(ld_funct3, ld_addr[1:0]);
        w_any   = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int k = 0; k < SB_DEPTH; k++) begin
            w_idx = r_head + PTR_W'(k);
            if (w_ent[w_idx].valid &&
                (w_ent[w_idx].waddr == SB_WA_MAX'(w_ld_waddr))) begin
                w_any = 1'b1;
                w_sel = w_idx;
            end
        end
        w_cover = w_any && ((w_ent[w_sel].be & w_req) == w_req);
    end

    // Forwarded word keeps only the lanes the matching entry actually holds.
    always_comb begin
        ld_hit      = ld_valid && w_cover;
        ld_stall    = ld_valid && w_any && !w_cover;
        ld_fwd_data = '0;
        if (ld_hit) begin
            for (int b = 0; b < 4; b++) begin
                ld_fwd_data[8*b +: 8] = w_ent[w_sel].be[b] ? w_ent[w_sel].data[8*b +: 8] : 8'h00;
            end
        end
    end

    // Memory write port driven from the head entry, zero when nothing is pending.
    always_comb begin
        mem_write = w_pop;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (!w_empty) begin
            mem_addr  = {r_waddr[r_head], 2'b00};
            mem_wdata = r_data[r_head];
            mem_be    = r_be[r_head];
        end
    end

    assign st_ready    = !w_full;
    assign st_misalign = r_misalign;
    assign empty       = w_empty;
    assign count       = r_count;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with hand-computed expected values.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_valid;
    logic        st_ready;
    logic [8:0]  st_addr;
    logic [31:0] st_data;
    logic [2:0]  st_funct3;
    logic        st_misalign;
    logic        ld_valid;
    logic [8:0]  ld_addr;
    logic [2:0]  ld_funct3;
    logic        ld_hit;
    logic [31:0] ld_fwd_data;
    logic        ld_stall;
    logic        drain_ok;
    logic        mem_write;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        empty;
    logic [2:0]  count;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    store_buffer #(.SB_DEPTH(4), .DM_ADDRESS(9), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
        .st_data(st_data), .st_funct3(st_funct3), .st_misalign(st_misalign),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_funct3(ld_funct3),
        .ld_hit(ld_hit), .ld_fwd_data(ld_fwd_data), .ld_stall(ld_stall),
        .drain_ok(drain_ok), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .empty(empty), .count(count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle store request; returns 2 time units after the capturing edge.
    task automatic push(input logic [2:0] f3, input logic [8:0] a, input logic [31:0] d);
        st_valid  = 1'b1;
        st_funct3 = f3;
        st_addr   = a;
        st_data   = d;
        step();
        st_valid = 1'b0;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_funct3 = '0;
        ld_valid = 1'b0; ld_addr = '0; ld_funct3 = '0; drain_ok = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty", 32'(empty), 1);
        chk("rst_count", 32'(count), 0);
        chk("rst_ready", 32'(st_ready), 1);
        chk("rst_mwrite", 32'(mem_write), 0);
        chk("rst_mis", 32'(st_misalign), 0);
        chk("rst_maddr", 32'(mem_addr), 0);
        rst_n = 1'b1;
        step();

        // Single word store drains on the next cycle.
        drain_ok = 1'b1;
        push(3'b010, 9'h010, 32'h12345678);
        chk("sw_mwrite", 32'(mem_write), 1);
        chk("sw_maddr", 32'(mem_addr), 32'h010);
        chk("sw_mbe", 32'(mem_be), 32'hF);
        chk("sw_wdata", mem_wdata, 32'h12345678);
        step();
        chk("sw_empty", 32'(empty), 1);
        chk("sw_mwrite_off", 32'(mem_write), 0);

        // Byte store, then forwarding / stall / miss lookups.
        drain_ok = 1'b0;
        push(3'b000, 9'h013, 32'h000000AB);
        ld_valid = 1'b1; ld_funct3 = 3'b100; ld_addr = 9'h013;
        #1;
        chk("lbu_hit", 32'(ld_hit), 1);
        chk("lbu_fwd", ld_fwd_data, 32'hAB000000);
        chk("lbu_stall", 32'(ld_stall), 0);
        ld_funct3 = 3'b001; ld_addr = 9'h010;
        #1;
        chk("lh_stall", 32'(ld_stall), 1);
        chk("lh_hit", 32'(ld_hit), 0);
        ld_funct3 = 3'b010; ld_addr = 9'h024;
        #1;
        chk("miss_hit", 32'(ld_hit), 0);
        chk("miss_stall", 32'(ld_stall), 0);
        drain_ok = 1'b1;
        #1;
        chk("ld_blocks_drain", 32'(mem_write), 0);
        ld_valid = 1'b0;
        #1;
        chk("sb_mwrite", 32'(mem_write), 1);
        chk("sb_wdata", mem_wdata, 32'hABABABAB);
        chk("sb_mbe", 32'(mem_be), 32'h8);
        step();
        chk("sb_empty", 32'(empty), 1);

        // Same-cycle store and load do not forward; next cycle does.
        drain_ok = 1'b0;
        st_valid = 1'b1; st_funct3 = 3'b010; st_addr = 9'h030; st_data = 32'hCAFEF00D;
        ld_valid = 1'b1; ld_funct3 = 3'b010; ld_addr = 9'h030;
        #1;
        chk("same_cyc_hit", 32'(ld_hit), 0);
        step();
        st_valid = 1'b0;
        #1;
        chk("next_cyc_hit", 32'(ld_hit), 1);
        chk("next_cyc_fwd", ld_fwd_data, 32'hCAFEF00D);
        ld_valid = 1'b0; drain_ok = 1'b1;
        step();
        chk("fwd_empty", 32'(empty), 1);

        // Fill to full, reject a fifth, then drain in order across the wrap.
        drain_ok = 1'b0;
        for (int i = 0; i < 4; i++) push(3'b010, 9'(9'h040 + 4 * i), 32'hA0000000 + i);
        chk("full_count", 32'(count), 4);
        chk("full_ready", 32'(st_ready), 0);
        push(3'b010, 9'h050, 32'hDEADBEEF);
        chk("fifth_ignored", 32'(count), 4);
        drain_ok = 1'b1;
        #1;
        chk("full_ready_pop", 32'(st_ready), 0);
        for (int i = 0; i < 4; i++) begin
            chk("drain_mwrite", 32'(mem_write), 1);
            chk("drain_addr", 32'(mem_addr), 32'h040 + 4 * i);
            chk("drain_data", mem_wdata, 32'hA0000000 + i);
            step();
        end
        chk("drain_empty", 32'(empty), 1);

        // Push and pop in one cycle leave the count unchanged.
        drain_ok = 1'b0;
        push(3'b010, 9'h060, 32'h00000060);
        drain_ok = 1'b1;
        push(3'b010, 9'h064, 32'h00000064);
        chk("pushpop_count", 32'(count), 1);
        chk("pushpop_addr", 32'(mem_addr), 32'h064);
        step();
        chk("pushpop_empty", 32'(empty), 1);

        // Misaligned stores are rejected with a one-cycle pulse.
        drain_ok = 1'b0;
        push(3'b001, 9'h011, 32'h0000BEEF);
        chk("sh_mis_pulse", 32'(st_misalign), 1);
        chk("sh_mis_count", 32'(count), 0);
        step();
        chk("sh_mis_clear", 32'(st_misalign), 0);
        push(3'b010, 9'h012, 32'h11223344);
        chk("sw_mis_pulse", 32'(st_misalign), 1);
        chk("sw_mis_count", 32'(count), 0);
        step();
        chk("sw_mis_clear", 32'(st_misalign), 0);

        // Two bytes into one word, then an upper halfword store.
        push(3'b000, 9'h020, 32'h00000011);
        push(3'b000, 9'h021, 32'h00000022);
        push(3'b001, 9'h026, 32'h0000BEEF);
        drain_ok = 1'b1;
`ifdef STORE_BUFFER_COALESCE_EN
        chk("coal_count", 32'(count), 2);
        #1;
        chk("coal_addr", 32'(mem_addr), 32'h020);
        chk("coal_be", 32'(mem_be), 32'h3);
        chk("coal_data", mem_wdata, 32'h11112211);
        step();
`else
        chk("nocoal_count", 32'(count), 3);
        #1;
        chk("nocoal_be0", 32'(mem_be), 32'h1);
        chk("nocoal_data0", mem_wdata, 32'h11111111);
        step();
        chk("nocoal_be1", 32'(mem_be), 32'h2);
        chk("nocoal_data1", mem_wdata, 32'h22222222);
        step();
`endif
        chk("sh_addr", 32'(mem_addr), 32'h024);
        chk("sh_be", 32'(mem_be), 32'hC);
        chk("sh_data", mem_wdata, 32'hBEEFBEEF);
        step();
        chk("sh_empty", 32'(empty), 1);

        // Asynchronous reset discards pending stores.
        drain_ok = 1'b0;
        for (int i = 0; i < 3; i++) push(3'b010, 9'(9'h080 + 4 * i), 32'h5A5A0000 + i);
        chk("pre_rst_count", 32'(count), 3);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        drain_ok = 1'b1;
        #1;
        chk("arst_empty", 32'(empty), 1);
        chk("arst_count", 32'(count), 0);
        chk("arst_mwrite", 32'(mem_write), 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("post_rst_nowrite", 32'(mem_write), 0);
            step();
        end
        chk("post_rst_empty", 32'(empty), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
